// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw active-low push-button and debounces it to button_n_clean.
// Define DEBOUNCER_EDGE_PULSE_EN to add registered one-cycle pressed/released pulses.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
`ifdef DEBOUNCER_EDGE_PULSE_EN
    output logic pressed,
    output logic released,
`endif
    output logic button_n_clean
);

    // state       | meaning
    // STABLE_HIGH | button released, output 1, waiting for a low at sync_out
    // CHECK_LOW   | sync_out low, counting stable cycles before declaring a press
    // STABLE_LOW  | button pressed, output 0, waiting for a high at sync_out
    // CHECK_HIGH  | sync_out high, counting stable cycles before declaring a release

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        STABLE_HIGH = 2'd0,
        CHECK_LOW   = 2'd1,
        STABLE_LOW  = 2'd2,
        CHECK_HIGH  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;

    // Idle level of the pin is 1, so the chain resets to 1 to avoid a fake press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
            clean_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        case (state_q)
            STABLE_HIGH: begin
                if (!sync_out) begin
                    state_d = CHECK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_LOW: begin
                if (sync_out) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_LOW: begin
                if (sync_out) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_HIGH: begin
                if (!sync_out) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_HIGH;
                cnt_d   = '0;
                clean_d = 1'b1;
            end
        endcase
    end

    assign button_n_clean = clean_q;

`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic pressed_q, pressed_d;
    logic released_q, released_d;

    // Pulses are registered alongside the level, so each covers the cycle after the output edge.
    assign pressed_d  = clean_q & ~clean_d;
    assign released_d = ~clean_q & clean_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign pressed  = pressed_q;
    assign released = released_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=8 (latency 11 edges).
// Pulse outputs are compared only when built with DEBOUNCER_EDGE_PULSE_EN.
module tb_button_debouncer;

    typedef struct {
        logic  bn;
        logic  clean;
        logic  pr;
        logic  rel;
        string name;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    logic button_n;
    logic button_n_clean;
`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic pressed;
    logic released;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .button_n      (button_n),
`ifdef DEBOUNCER_EDGE_PULSE_EN
        .pressed       (pressed),
        .released      (released),
`endif
        .button_n_clean(button_n_clean)
    );

    task automatic add(input string name, input logic bn, input int n,
                       input logic c, input logic p, input logic r);
        for (int i = 0; i < n; i++) tbl.push_back('{bn, c, p, r, name});
    endtask

    task automatic check_now(input vec_t v);
        vectors++;
        if (button_n_clean !== v.clean) begin
            miscompares++;
            $display("FAIL %s (vector %0d): button_n_clean=%b required %b",
                     v.name, vectors, button_n_clean, v.clean);
        end
`ifdef DEBOUNCER_EDGE_PULSE_EN
        if (pressed !== v.pr) begin
            miscompares++;
            $display("FAIL %s (vector %0d): pressed=%b required %b", v.name, vectors, pressed, v.pr);
        end
        if (released !== v.rel) begin
            miscompares++;
            $display("FAIL %s (vector %0d): released=%b required %b", v.name, vectors, released, v.rel);
        end
        if (pressed && released) begin
            miscompares++;
            $display("FAIL %s (vector %0d): pressed and released both high, required at most one",
                     v.name, vectors);
        end
`endif
    endtask

    task automatic apply(input vec_t v);
        button_n = v.bn;
        @(posedge clock);
        #1;
        check_now(v);
    endtask

    initial begin
        reset_n  = 1'b0;
        button_n = 1'b0;

        // Pressed during reset: nothing escapes until reset ends, then full latency.
        repeat (3) begin
            @(posedge clock);
            #1;
            check_now('{1'b0, 1'b1, 1'b0, 1'b0, "reset_hold"});
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 14; i++) apply('{1'b0, i < 11, i == 11, 1'b0, "reset_hold_press"});

        // Release from STABLE_LOW
        add("release",     1'b1, 10, 1'b0, 1'b0, 1'b0);
        add("release_e11", 1'b1,  1, 1'b1, 1'b0, 1'b1);
        add("release_hold",1'b1,  3, 1'b1, 1'b0, 1'b0);
        // Low lasting exactly DEBOUNCE_CYCLES is rejected
        add("low8_reject", 1'b0,  8, 1'b1, 1'b0, 1'b0);
        add("low8_after",  1'b1, 12, 1'b1, 1'b0, 1'b0);
        // Low lasting DEBOUNCE_CYCLES+1 at sync_out is accepted, then released
        add("low9",        1'b0,  9, 1'b1, 1'b0, 1'b0);
        add("low9_e10",    1'b1,  1, 1'b1, 1'b0, 1'b0);
        add("low9_e11",    1'b1,  1, 1'b0, 1'b1, 1'b0);
        add("low9_rel",    1'b1,  8, 1'b0, 1'b0, 1'b0);
        add("low9_rel_e20",1'b1,  1, 1'b1, 1'b0, 1'b1);
        add("low9_idle",   1'b1,  3, 1'b1, 1'b0, 1'b0);
        // Clean press
        add("press",       1'b0, 10, 1'b1, 1'b0, 1'b0);
        add("press_e11",   1'b0,  1, 1'b0, 1'b1, 1'b0);
        add("press_hold",  1'b0,  3, 1'b0, 1'b0, 1'b0);
        // Single-cycle glitch while pressed
        add("glitch",      1'b1,  1, 1'b0, 1'b0, 1'b0);
        add("glitch_after",1'b0, 15, 1'b0, 1'b0, 1'b0);
        // Release again to set up the bounce
        add("release2",    1'b1, 10, 1'b0, 1'b0, 1'b0);
        add("release2_e11",1'b1,  1, 1'b1, 1'b0, 1'b1);
        add("release2_hold",1'b1, 3, 1'b1, 1'b0, 1'b0);
        // Bounce low5/high3/low6/high2 then held low
        add("bounce_l5",   1'b0,  5, 1'b1, 1'b0, 1'b0);
        add("bounce_h3",   1'b1,  3, 1'b1, 1'b0, 1'b0);
        add("bounce_l6",   1'b0,  6, 1'b1, 1'b0, 1'b0);
        add("bounce_h2",   1'b1,  2, 1'b1, 1'b0, 1'b0);
        add("bounce_held", 1'b0, 10, 1'b1, 1'b0, 1'b0);
        add("bounce_e11",  1'b0,  1, 1'b0, 1'b1, 1'b0);
        add("bounce_hold", 1'b0,  3, 1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) apply(tbl[i]);

        // Reset during a release count (CHECK_HIGH, cnt=5): output snaps to 1 with no pulse.
        for (int i = 1; i <= 7; i++) apply('{1'b1, 1'b0, 1'b0, 1'b0, "rst_mid_high_count"});
        reset_n = 1'b0;
        #1;
        check_now('{1'b1, 1'b1, 1'b0, 1'b0, "rst_mid_high_async"});
        repeat (2) begin
            @(posedge clock);
            #1;
            check_now('{1'b1, 1'b1, 1'b0, 1'b0, "rst_mid_high_hold"});
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) apply('{1'b1, 1'b1, 1'b0, 1'b0, "rst_mid_high_after"});

        // Reset during a press count (CHECK_LOW, cnt=5), then full latency after deassert.
        for (int i = 1; i <= 7; i++) apply('{1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_low_count"});
        reset_n = 1'b0;
        #1;
        check_now('{1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_low_async"});
        repeat (2) begin
            @(posedge clock);
            #1;
            check_now('{1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_low_hold"});
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 13; i++) apply('{1'b0, i < 11, i == 11, 1'b0, "rst_mid_low_after"});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
